fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 19 +
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-producer FIFO write arbiter.
//   DefaultDataW : default producer/FIFO data width
//   arb_state_e  : arbiter FSM state (idle, serving producer 0, serving producer 1)
//   serve_state  : maps a producer index to its serving state
package fifo_arb_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServe0 = 2'd1,
    StServe1 = 2'd2
  } arb_state_e;

  function automatic arb_state_e serve_state(input logic idx);
    return idx ? StServe1 : StServe0;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter.sv
// Two-producer write arbiter in front of a FIFO write port. One producer owns the
// port at a time; ownership passes to the other producer after MAX_BURST transfers
// (if it is waiting) or as soon as the owner stops requesting.
//   clk            : clock, all state on the rising edge
//   rst            : synchronous reset, active low
//   req0/req1      : producer holds a valid word (held until granted)
//   data0/data1    : producer words
//   gnt0/gnt1      : word accepted this cycle
//   full           : FIFO full flag
//   WREN/data_in   : FIFO write enable / write data (zero when not writing)
//   stall          : owner is requesting but the FIFO is full
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  input  logic              full,
  output logic              WREN,
  output logic [DATA_W-1:0] data_in,
  output logic              stall
);

  localparam logic [3:0] BurstLast = 4'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  logic [3:0] burst_cnt_q, burst_cnt_d;
  logic       last_q, last_d;

  // Index of the current owner, and the request lines seen from its point of view.
  logic own;
  logic req_own;
  logic req_oth;

  always_comb begin
    own     = (state_q == StServe1);
    req_own = own ? req1 : req0;
    req_oth = own ? req0 : req1;
  end

  // Grants are masked by reset so a burst is cut off in the reset cycle itself.
  always_comb begin
    gnt0    = rst && (state_q == StServe0) && req0 && !full;
    gnt1    = rst && (state_q == StServe1) && req1 && !full;
    WREN    = gnt0 | gnt1;
    data_in = gnt0 ? data0 : (gnt1 ? data1 : '0);
    stall   = rst && (state_q != StIdle) && req_own && full;
  end

  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_d      = last_q;
    unique case (state_q)
      StIdle: begin
        // Tie goes to the producer that was not served last.
        if (req0 && req1) begin
          state_d = serve_state(!last_q);
        end else if (req0) begin
          state_d = StServe0;
        end else if (req1) begin
          state_d = StServe1;
        end
      end
      StServe0, StServe1: begin
        // A full FIFO freezes everything; stalled cycles do not count toward the burst.
        if (!full) begin
          if (!req_own) begin
            state_d     = req_oth ? serve_state(!own) : StIdle;
            burst_cnt_d = '0;
            last_d      = own;
          end else if (burst_cnt_q == BurstLast) begin
            burst_cnt_d = '0;
            if (req_oth) begin
              state_d = serve_state(!own);
              last_d  = own;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      burst_cnt_q <= '0;
      last_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed grant sequences with hand-written expectations,
// a per-cycle behavioural model check, and a protocol-respecting random phase.
module tb_fifo_wr_arbiter;

  localparam int unsigned DataW     = 8;
  localparam int unsigned MaxBurst  = 4;
  localparam int          LiveBound = 2 * MaxBurst + 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0, full = 1'b0;
  logic [DataW-1:0] data0 = '0, data1 = '0;
  logic             gnt0, gnt1, WREN, stall;
  logic [DataW-1:0] data_in;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .DATA_W   (DataW),
    .MAX_BURST(MaxBurst)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .data0  (data0),
    .data1  (data1),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .full   (full),
    .WREN   (WREN),
    .data_in(data_in),
    .stall  (stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the port (-1 none), transfers in the current burst, last served.
  int owner = -1;
  int burst = 0;
  int last  = 1;
  bit mvalid = 1'b0;
  int wait0 = 0, wait1 = 0;

  always @(negedge clk) begin
    logic eg0, eg1, es;
    logic [DataW-1:0] ed;
    bit ri, rj;
    if (mvalid) begin
      eg0 = rst && owner == 0 && req0 && !full;
      eg1 = rst && owner == 1 && req1 && !full;
      es  = rst && full && ((owner == 0 && req0) || (owner == 1 && req1));
      ed  = eg0 ? data0 : (eg1 ? data1 : '0);
      chk("model_gnt0", 32'(gnt0), 32'(eg0));
      chk("model_gnt1", 32'(gnt1), 32'(eg1));
      chk("model_wren", 32'(WREN), 32'(eg0 | eg1));
      chk("model_data", 32'(data_in), 32'(ed));
      chk("model_stall", 32'(stall), 32'(es));
      chk("never_wren_full", 32'(WREN && full), 32'd0);
      chk("never_both_gnt", 32'(gnt0 && gnt1), 32'd0);
      if (!rst || !req0 || gnt0) wait0 = 0; else if (!full) wait0++;
      if (!rst || !req1 || gnt1) wait1 = 0; else if (!full) wait1++;
      chk("live0", 32'(wait0 <= LiveBound), 32'd1);
      chk("live1", 32'(wait1 <= LiveBound), 32'd1);
    end
    // Advance the model across the coming rising edge.
    if (!rst) begin
      owner = -1; burst = 0; last = 1; mvalid = 1'b1;
    end else if (mvalid) begin
      if (owner < 0) begin
        if (req0 && req1) owner = 1 - last;
        else if (req0) owner = 0;
        else if (req1) owner = 1;
      end else if (!full) begin
        ri = (owner == 0) ? req0 : req1;
        rj = (owner == 0) ? req1 : req0;
        if (!ri) begin
          last  = owner;
          burst = 0;
          owner = rj ? 1 - owner : -1;
        end else begin
          burst++;
          if (burst == MaxBurst) begin
            burst = 0;
            if (rj) begin
              last  = owner;
              owner = 1 - owner;
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; full = 1'b0;
    cyc();
  endtask

  function automatic logic bit_at(input string s, input int k);
    return s[k] == "1";
  endfunction

  // One character per cycle; gs: 0 no grant, 1 gnt0, 2 gnt1.
  task automatic run_vec(input string nm, input string rs, input string r0, input string r1,
                         input string fl, input string gs, input string ss,
                         input logic [DataW-1:0] d0, input logic [DataW-1:0] d1);
    int eg;
    logic [DataW-1:0] ed;
    do_reset();
    data0 = d0;
    data1 = d1;
    for (int k = 0; k < gs.len(); k++) begin
      cyc();
      rst  = bit_at(rs, k);
      req0 = bit_at(r0, k);
      req1 = bit_at(r1, k);
      full = bit_at(fl, k);
      #2;
      eg = int'(gs[k]) - 48;
      ed = (eg == 1) ? d0 : ((eg == 2) ? d1 : '0);
      chk($sformatf("%s/gnt c%0d", nm, k), 32'({gnt1, gnt0}), 32'(eg));
      chk($sformatf("%s/wren c%0d", nm, k), 32'(WREN), 32'(eg != 0));
      chk($sformatf("%s/data c%0d", nm, k), 32'(data_in), 32'(ed));
      chk($sformatf("%s/stall c%0d", nm, k), 32'(stall), 32'(bit_at(ss, k)));
    end
  endtask

  initial begin
    logic g0s, g1s;
    // Reset state: outputs quiet during reset.
    cyc();
    cyc();
    chk("reset_gnt", 32'({gnt1, gnt0}), 32'd0);
    chk("reset_wren", 32'(WREN), 32'd0);
    chk("reset_data", 32'(data_in), 32'd0);
    chk("reset_stall", 32'(stall), 32'd0);

    // Single producer streaming.
    run_vec("solo0", "111111", "111111", "000000", "000000", "011111", "000000",
            8'h11, 8'h00);
    // Both requesting from reset: bursts of MaxBurst alternate, producer 0 first.
    run_vec("both", "11111111111", "11111111111", "11111111111", "00000000000",
            "01111222211", "00000000000", 8'hA0, 8'hB1);
    // Full for 3 cycles mid-burst: stall, then the burst finishes its remaining 2 writes.
    run_vec("full", "1111111111", "1111111111", "1111111111", "0001110000",
            "0110001122", "0001110000", 8'h3C, 8'h4D);
    // Producer 1 drops after 3 writes as producer 0 rises: no trip through idle.
    run_vec("handoff", "1111111", "0000111", "1111000", "0000000",
            "0222011", "0000000", 8'h21, 8'h12);
    // Reset mid SERVE1 burst: no write in the reset cycle, then tie goes to producer 0.
    run_vec("midrst", "11110111", "00011111", "11111111", "00000000",
            "02220011", "00000000", 8'h77, 8'h88);
    // Lone producer bursts past MaxBurst; rival joins and takes over after the wrap.
    run_vec("wrap", "1111111111111", "1111111111111", "0000001111111", "0000000000000",
            "0111111112222", "0000000000000", 8'h5A, 8'hC3);

    // Random traffic obeying the hold-until-granted rule, checked by the model.
    do_reset();
    cyc();
    rst = 1'b1;
    g0s = 1'b0;
    g1s = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (k != 0) cyc();
      if (!req0 || g0s) begin
        req0  = ($urandom_range(0, 3) != 0);
        data0 = DataW'($urandom);
      end
      if (!req1 || g1s) begin
        req1  = ($urandom_range(0, 3) != 0);
        data1 = DataW'($urandom);
      end
      full = ($urandom_range(0, 3) == 0);
      #2;
      g0s = gnt0;
      g1s = gnt1;
    end
    cyc();
    full = 1'b0;
    cyc();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
